// File: rtl/man_encoder_tx.sv
// Manchester (IEEE 802.3 polarity) serial transmitter: sync low/high preamble,
// payload MSB first, optional odd-parity bit; registered line output.
module man_encoder_tx #(
    parameter int HALF_BIT = 4,
    parameter int DATA_W   = 8,
    parameter int PAR_EN   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    // state    | meaning
    // IDLE     | line low, waiting for start
    // SYNC_LO  | preamble low, 3 half-bits
    // SYNC_HI  | preamble high, 3 half-bits
    // DATA     | payload (+ parity) bits, two half-bits each
    typedef enum logic [1:0] {IDLE, SYNC_LO, SYNC_HI, DATA} state_t;

    localparam int NB    = DATA_W + ((PAR_EN != 0) ? 1 : 0);
    localparam int CYC_W = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int BIT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);

    state_t           state, state_n;
    logic [CYC_W-1:0] cyc_cnt, cyc_n;
    logic [1:0]       half_cnt, half_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [NB-1:0]    sreg, sreg_n;
    logic [NB-1:0]    load_val;
    logic             dout_n, busy_n, done_n;
    logic             half_end;

    generate
        if (PAR_EN != 0) begin : g_par
            assign load_val = {din, ~^din};
        end else begin : g_nopar
            assign load_val = din;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cyc_cnt  <= cyc_n;
            half_cnt <= half_n;
            bit_cnt  <= bit_n;
            sreg     <= sreg_n;
            dout     <= dout_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cyc_n    = cyc_cnt;
        half_n   = half_cnt;
        bit_n    = bit_cnt;
        sreg_n   = sreg;
        done_n   = 1'b0;
        half_end = (cyc_cnt == CYC_LAST);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SYNC_LO;
                    cyc_n   = '0;
                    half_n  = '0;
                    bit_n   = '0;
                    sreg_n  = load_val;
                end
            end
            SYNC_LO, SYNC_HI: begin
                if (half_end) begin
                    cyc_n = '0;
                    if (half_cnt == 2'd2) begin
                        state_n = (state == SYNC_LO) ? SYNC_HI : DATA;
                        half_n  = '0;
                        bit_n   = '0;
                    end else begin
                        half_n = half_cnt + 2'd1;
                    end
                end else begin
                    cyc_n = cyc_cnt + CYC_W'(1);
                end
            end
            DATA: begin
                if (half_end) begin
                    cyc_n = '0;
                    if (half_cnt == 2'd0) begin
                        half_n = 2'd1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_n = IDLE;
                        half_n  = '0;
                        bit_n   = '0;
                        sreg_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        half_n = '0;
                        bit_n  = bit_cnt + BIT_W'(1);
                        sreg_n = sreg << 1;
                    end
                end else begin
                    cyc_n = cyc_cnt + CYC_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Output is derived from the next state so the flop shows the new half-bit on its first cycle.
        case (state_n)
            SYNC_HI: dout_n = 1'b1;
            DATA:    dout_n = (half_n == 2'd0) ? ~sreg_n[NB-1] : sreg_n[NB-1];
            default: dout_n = 1'b0;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_man_encoder_tx.sv
// Bench for man_encoder_tx: default and odd-parity instances checked against a
// half-bit waveform model plus a mid-bit sampling decoder.
module tb_man_encoder_tx;

    localparam int HB = 4;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] din_a, din_b;
    logic       dout_a, busy_a, done_a;
    logic       dout_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    bit   exp_wave[$];
    logic samples[0:127];

    man_encoder_tx #(.HALF_BIT(HB), .DATA_W(8), .PAR_EN(0)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .din(din_a),
        .dout(dout_a), .busy(busy_a), .done(done_a)
    );

    man_encoder_tx #(.HALF_BIT(HB), .DATA_W(8), .PAR_EN(1)) u_par (
        .clk(clk), .rst(rst), .start(start_b), .din(din_b),
        .dout(dout_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] obs(input int sel);
        return (sel == 0) ? {dout_a, busy_a, done_a} : {dout_b, busy_b, done_b};
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] d);
        if (sel == 0) begin
            start_a = st;
            din_a   = d;
        end else begin
            start_b = st;
            din_b   = d;
        end
    endtask

    // Frame as a list of half-bit levels: 3 low, 3 high, then 01 for a one, 10 for a zero.
    function automatic logic [8:0] word_of(input logic [7:0] d, input bit par);
        bit p;
        p = ($countones(d) % 2 == 0);
        return par ? {d, p} : {1'b0, d};
    endfunction

    task automatic build_wave(input logic [7:0] d, input bit par);
        logic [8:0] w;
        int nb;
        exp_wave.delete();
        for (int i = 0; i < 3; i++) exp_wave.push_back(1'b0);
        for (int i = 0; i < 3; i++) exp_wave.push_back(1'b1);
        nb = par ? 9 : 8;
        w  = word_of(d, par);
        for (int i = nb - 1; i >= 0; i--) begin
            if (w[i]) begin
                exp_wave.push_back(1'b0);
                exp_wave.push_back(1'b1);
            end else begin
                exp_wave.push_back(1'b1);
                exp_wave.push_back(1'b0);
            end
        end
    endtask

    // Called at a negedge; accepted at the next posedge; returns at the negedge of the done cycle.
    task automatic run_frame(input int sel, input logic [7:0] d, input bit hold, input string tag);
        logic [2:0] o;
        logic [8:0] dec;
        int f, nb;
        bit par;
        par = (sel == 1);
        nb  = par ? 9 : 8;
        build_wave(d, par);
        f = exp_wave.size() * HB;
        drive(sel, 1'b1, d);
        @(posedge clk);
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            if (hold) drive(sel, 1'b1, 8'($urandom));
            else if (k == 0) drive(sel, 1'b0, 8'($urandom));
            o = obs(sel);
            samples[k] = o[2];
            check({tag, "_dout"}, 32'(o[2]), 32'(exp_wave[k / HB]));
            check({tag, "_busy"}, 32'(o[1]), 32'd1);
            check({tag, "_done_early"}, 32'(o[0]), 32'd0);
        end
        @(negedge clk);
        o = obs(sel);
        check({tag, "_end_dout"}, 32'(o[2]), 32'd0);
        check({tag, "_end_busy"}, 32'(o[1]), 32'd0);
        check({tag, "_done"}, 32'(o[0]), 32'd1);
        dec = '0;
        for (int i = 0; i < nb; i++) dec = {dec[7:0], samples[(6 + 2 * i + 1) * HB + HB / 2]};
        check({tag, "_decoded"}, 32'(dec), 32'(word_of(d, par)));
    endtask

    task automatic idle_check(input int sel, input int n, input string tag);
        logic [2:0] o;
        drive(sel, 1'b0, 8'($urandom));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            o = obs(sel);
            check(tag, 32'(o), 32'd0);
        end
    endtask

    initial begin
        logic [2:0] o;
        rst = 1'b0;
        drive(0, 1'b1, 8'h5A);
        drive(1, 1'b1, 8'hC3);

        // reset held with start asserted
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_a", 32'(obs(0)), 32'd0);
            check("rst_b", 32'(obs(1)), 32'd0);
        end
        rst = 1'b1;
        drive(1, 1'b0, 8'h00);
        idle_check(0, 2, "idle_after_rst");

        run_frame(0, 8'hA5, 1'b0, "a5");
        idle_check(0, 3, "idle_a5");

        run_frame(1, 8'h03, 1'b0, "par03");
        idle_check(1, 2, "idle_par03");
        run_frame(1, 8'h07, 1'b0, "par07");
        idle_check(1, 2, "idle_par07");

        // start held through frame, back-to-back second frame
        run_frame(0, 8'h3C, 1'b1, "hold1");
        run_frame(0, 8'hC3, 1'b0, "b2b");
        idle_check(0, 2, "idle_b2b");

        // reset in the middle of data bit 3
        drive(0, 1'b1, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (24 + 24 + 5) @(negedge clk);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        o = obs(0);
        check("midrst_dout", 32'(o[2]), 32'd0);
        check("midrst_busy", 32'(o[1]), 32'd0);
        check("midrst_done", 32'(o[0]), 32'd0);
        rst = 1'b1;
        idle_check(0, 60, "post_rst_idle");
        run_frame(0, 8'($urandom), 1'b0, "post_rst");
        idle_check(0, 1, "idle_post_rst");

        for (int n = 0; n < 30; n++) begin
            run_frame(0, 8'($urandom), 1'b0, "rnd_a");
            if ($urandom_range(1, 0) == 1) idle_check(0, $urandom_range(3, 1), "rnd_a_idle");
        end
        for (int n = 0; n < 20; n++) begin
            run_frame(1, 8'($urandom), 1'b0, "rnd_b");
            idle_check(1, 1, "rnd_b_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
